// File: rtl/xdma_req_rr_manager.sv
// rtl/xdma_req_rr_manager.sv - round-robin burst-locking request manager for the xDMA AXI adapter
module xdma_req_rr_manager #(
  parameter type data_t          = logic,
  parameter type xdma_req_desc_t = logic,
  parameter int  N_INP           = 4,
  parameter int  LEN_W           = 16,
  localparam int LOG_N_INP       = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  data_t                inp_data_i  [N_INP],
  input  logic [N_INP-1:0]     inp_valid_i,
  output logic [N_INP-1:0]     inp_ready_o,
  input  xdma_req_desc_t       inp_desc_i  [N_INP],
  input  logic [LEN_W-1:0]     inp_len_i   [N_INP],
  output data_t                oup_data_o,
  output logic                 oup_valid_o,
  input  logic                 oup_ready_i,
  output xdma_req_desc_t       oup_desc_o,
  input  logic                 abort_i,
  output logic [LOG_N_INP-1:0] idx_o,
  output logic                 start_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [LEN_W-1:0]     beat_cnt_o
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t               r_state;
  logic [LOG_N_INP-1:0] r_ptr;
  logic [LOG_N_INP-1:0] r_idx;
  logic [LEN_W-1:0]     r_cnt;
  logic [LEN_W-1:0]     r_len;

  logic                 w_busy;
  logic                 w_pass;
  logic                 w_found;
  logic [LOG_N_INP-1:0] w_win;
  logic [LOG_N_INP-1:0] w_ptr_nxt;
  logic                 w_beat;
  logic                 w_last;

  assign w_busy = (r_state == S_BUSY);
  // abort blanks the handshake in its cycle, so a coincident last beat never completes
  assign w_pass = w_busy && !abort_i;

  // first valid channel at or after the pointer, wrapping around
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < N_INP; i++) begin
      j = (int'(r_ptr) + i) % N_INP;
      if (!w_found && inp_valid_i[j]) begin
        w_found = 1'b1;
        w_win   = j[LOG_N_INP-1:0];
      end
    end
  end

  assign w_ptr_nxt = (r_idx == LOG_N_INP'(N_INP - 1)) ? '0 : r_idx + 1'b1;

  // pass-through of the locked channel; everything is zero outside a burst
  always_comb begin
    inp_ready_o = '0;
    oup_valid_o = 1'b0;
    oup_data_o  = '0;
    oup_desc_o  = '0;
    if (w_busy) begin
      oup_data_o = inp_data_i[r_idx];
      oup_desc_o = inp_desc_i[r_idx];
    end
    if (w_pass) begin
      oup_valid_o        = inp_valid_i[r_idx];
      inp_ready_o[r_idx] = oup_ready_i;
    end
  end

  assign w_beat     = oup_valid_o && oup_ready_i;
  assign w_last     = w_beat && (r_cnt == r_len);
  assign start_o    = !rst_i && (r_state == S_IDLE) && w_found;
  assign done_o     = !rst_i && w_last;
  assign busy_o     = w_busy;
  assign idx_o      = r_idx;
  assign beat_cnt_o = r_cnt;

  // grant / burst-lock state machine with beat counting
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_idx   <= w_win;
            r_len   <= inp_len_i[w_win];
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (abort_i || w_last) begin
            r_state <= S_IDLE;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= '0;
          end else if (w_beat) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
